// File: rtl/sched_pkg.sv
// Shared types and default sizing for the credit-gated round-robin scheduler.
package sched_pkg;
  typedef enum logic {IDLE, HOLD} sched_state_t;

  localparam int DEF_NUM_IN    = 4;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_CREDITS   = 8;
  localparam int DEF_MAX_BURST = 4;

  // Index width that stays >= 1 even for a single-entry space.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or after ptr wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/credit_rr_sched.sv
// Credit-gated round-robin scheduler with burst hold for a non-stallable shared unit.
// Optional SCHED_STATS_EN adds per-requester grant counters and a stall-cycle counter.
module credit_rr_sched
  import sched_pkg::*;
#(
  parameter int NUM_IN    = DEF_NUM_IN,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CREDITS   = DEF_CREDITS,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int IW = idx_w(NUM_IN),
  localparam int CW = $clog2(CREDITS + 1),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            us_valid,
  input  logic [NUM_IN-1:0][WIDTH-1:0] us_data,
  output logic [NUM_IN-1:0]            us_stall,
  output logic                         issue_valid,
  output logic [WIDTH-1:0]             issue_data,
  output logic [IW-1:0]                issue_id,
  input  logic                         cred_return,
  output logic [CW-1:0]                credits
`ifdef SCHED_STATS_EN
  ,
  output logic [NUM_IN-1:0][31:0]      grant_cnt,
  output logic [31:0]                  stall_cycles
`endif
);
  sched_state_t      state;
  logic [IW-1:0]     ptr, owner, pick_ptr, pidx, win;
  logic [BW-1:0]     burst_cnt;
  logic [NUM_IN-1:0] pgnt, grant;
  logic              pany, cred_ok, hold_go, rel, accept, ret_ok;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == NUM_IN - 1) ? '0 : i + 1'b1;
  endfunction

  assign cred_ok  = (credits != '0);
  assign hold_go  = (state == HOLD) && us_valid[owner];
  assign rel      = (state == HOLD) && !us_valid[owner];
  // A dropping owner hands over in the same cycle, so arbitration restarts past it.
  assign pick_ptr = rel ? nxt(owner) : ptr;

  rr_pick #(.N(NUM_IN), .IW(IW)) u_pick (
    .req (us_valid),
    .ptr (pick_ptr),
    .gnt (pgnt),
    .idx (pidx),
    .any (pany)
  );

  always_comb begin
    grant = '0;
    win   = pidx;
    if (hold_go) begin
      win = owner;
      if (cred_ok) grant[owner] = 1'b1;
    end else if (cred_ok) begin
      grant = pgnt;
    end
  end

  assign accept   = hold_go ? cred_ok : (cred_ok && pany);
  assign us_stall = us_valid & ~grant;

  // Return while already full is illegal; it is ignored so the count saturates.
  assign ret_ok = cred_return && (credits != CW'(CREDITS));

  always_ff @(posedge clk or posedge rst)
    if (rst) credits <= CW'(CREDITS);
    else if (accept && !ret_ok) credits <= credits - 1'b1;
    else if (!accept && ret_ok) credits <= credits + 1'b1;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      burst_cnt   <= '0;
      issue_valid <= 1'b0;
      issue_data  <= '0;
      issue_id    <= '0;
    end else begin
      issue_valid <= accept;
      if (accept) begin
        issue_data <= us_data[win];
        issue_id   <= win;
      end
      if (rel) ptr <= nxt(owner);
      if (hold_go) begin
        if (accept) begin
          burst_cnt <= burst_cnt + 1'b1;
          if (burst_cnt == BW'(MAX_BURST - 1)) begin
            state <= IDLE;
            ptr   <= nxt(owner);
          end
        end
      end else if (accept) begin
        owner     <= win;
        burst_cnt <= BW'(1);
        if (MAX_BURST > 1) state <= HOLD;
        else begin
          state <= IDLE;
          ptr   <= nxt(win);
        end
      end else begin
        state <= IDLE;
      end
    end

  a_no_return_when_full: assert property (
    @(posedge clk) disable iff (rst) !(cred_return && credits == CW'(CREDITS)));

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant_cnt    <= '0;
      stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++)
        if (grant[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
      if ((|us_valid) && !accept) stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_credit_rr_sched.sv
// Scoreboard bench for credit_rr_sched: reference model pushes expected issues, monitor pops.
module tb_credit_rr_sched;
  localparam int N    = 4;
  localparam int W    = 32;
  localparam int CRED = 8;
  localparam int MB   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      us_valid = '0;
  logic [N-1:0][W-1:0] us_data = '0;
  logic [N-1:0]      us_stall;
  logic              issue_valid;
  logic [W-1:0]      issue_data;
  logic [1:0]        issue_id;
  logic              cred_return = 1'b0;
  logic [3:0]        credits;
`ifdef SCHED_STATS_EN
  logic [N-1:0][31:0] grant_cnt;
  logic [31:0]        stall_cycles;
`endif

  always #5 clk = ~clk;

  credit_rr_sched #(.NUM_IN(N), .WIDTH(W), .CREDITS(CRED), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst         (rst),
    .us_valid    (us_valid),
    .us_data     (us_data),
    .us_stall    (us_stall),
    .issue_valid (issue_valid),
    .issue_data  (issue_data),
    .issue_id    (issue_id),
    .cred_return (cred_return),
    .credits     (credits)
`ifdef SCHED_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .stall_cycles(stall_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {int id; logic [W-1:0] data;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [W-1:0] last_data = '0;

  // Reference model: credit pool, rotating start, current burst owner (-1 = none).
  int m_cred, m_ptr, m_owner, m_burst;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cred = CRED; m_ptr = 0; m_owner = -1; m_burst = 0;
  endtask

  task automatic model_step(input logic [N-1:0] v, input bit cr, output int g);
    int c;
    g = -1;
    if (m_owner >= 0 && v[m_owner]) begin
      if (m_cred > 0) begin
        g = m_owner;
        m_burst++;
        if (m_burst == MB) begin
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end else begin
      if (m_owner >= 0) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
      if (m_cred > 0)
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (g < 0 && v[c]) g = c;
        end
      if (g >= 0) begin
        m_burst = 1;
        if (MB > 1) m_owner = g;
        else m_ptr = (g + 1) % N;
      end
    end
    m_cred = m_cred - ((g >= 0) ? 1 : 0) + (cr ? 1 : 0);
  endtask

  // Monitor: every presented beat must match the oldest expectation.
  always @(negedge clk) begin
    if (rst) last_data = '0;
    else if (issue_valid) begin
      if (sb.size() == 0) chk("spurious_issue", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("issue_id", 64'(issue_id), 64'(mon_e.id));
        chk("issue_data", 64'(issue_data), 64'(mon_e.data));
      end
      last_data = issue_data;
    end else begin
      chk("issue_data_hold", 64'(issue_data), 64'(last_data));
    end
  end

  task automatic cycle(input logic [N-1:0] v, input bit cr);
    int g;
    logic [N-1:0] gv;
    @(negedge clk); #1;
    us_valid    = v;
    cred_return = cr && (m_cred < CRED);
    #1;
    model_step(us_valid, cred_return, g);
    gv = '0;
    if (g >= 0) begin
      gv[g] = 1'b1;
      sb.push_back('{g, us_data[g]});
    end
    chk("us_stall", 64'(us_stall), 64'(us_valid & ~gv));
    @(posedge clk); #1;
    chk("credits", 64'(credits), 64'(m_cred));
    if (g >= 0) us_data[g] = $urandom();
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    us_valid = '0; cred_return = 1'b0; rst = 1'b1;
    #1;
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_issue_id", 64'(issue_id), 64'd0);
    chk("rst_issue_data", 64'(issue_data), 64'd0);
    chk("rst_credits", 64'(credits), 64'(CRED));
    chk("rst_sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();
    model_reset();
    @(negedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rv;
    for (int i = 0; i < N; i++) us_data[i] = $urandom();
    model_reset();
    do_reset();

    // Single requester: bursts chain back-to-back, credits 8 -> 2.
    repeat (6) cycle(4'b0001, 1'b0);
    chk("t1_credits", 64'(credits), 64'd2);
    repeat (6) cycle(4'b0000, 1'b1);

    // All requesting with replenishment: 4-beat bursts rotate without bubbles.
    do_reset();
    repeat (16) cycle(4'b1111, 1'b1);

    // Drain credits, then everyone stalls; one return admits exactly one beat.
    repeat (10) cycle(4'b1111, 1'b0);
    chk("t4_credits_zero", 64'(credits), 64'd0);
    cycle(4'b1111, 1'b1);
    cycle(4'b1111, 1'b1);
    chk("t5_credits_steady", 64'(credits), 64'd1);
    cycle(4'b1111, 1'b0);

    // Reset in the middle of req2's burst; next grant restarts at req0.
    do_reset();
    cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b0);
    do_reset();
    cycle(4'b1111, 1'b0);

    // Randomized traffic, biased toward busy requesters.
    for (int n = 0; n < 3000; n++) begin
      rv = '0;
      for (int i = 0; i < N; i++) rv[i] = ($urandom_range(0, 3) != 0);
      if (n % 500 == 250) do_reset();
      cycle(rv, $urandom_range(0, 2) != 0);
    end

    @(negedge clk); #2;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
